cisr_row_scheduler: RTL and testbench

- Front-end scheduler for the CISR decode path.
- Takes a stream of per-row nonzero counts and assigns each row, in ascending row order, to the lowest-index free lane of a LANES-wide slot array.
- Each cycle it emits, per lane, the row ID owning that lane's current nonzero, which feeds the multiply/accumulate lanes.
- Sequences one matrix pass per start pulse and signals completion.

---
 rtl/cisr_row_scheduler.sv | 130 +++++++++++++
 tb/tb_cisr_row_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cisr_row_scheduler.sv
// Row scheduler for the CISR decode path: places rows, in order, into the lowest
// free lane and reports per-lane row ownership while nonzeros are consumed.
module cisr_row_scheduler #(
  parameter int LANES = 4,
  parameter int ID_W  = 5,
  parameter int LEN_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ID_W-1:0]       num_rows,
  input  logic                  len_valid,
  input  logic [LEN_W-1:0]      len_data,
  output logic                  len_ready,
  input  logic                  advance,
  output logic [LANES-1:0]      lane_valid,
  output logic [LANES*ID_W-1:0] lane_row_id,
  output logic [LANES-1:0]      lane_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stateT;

  stateT             state, stateNext;
  logic [ID_W-1:0]   rowsQ, rowsNext;
  logic [ID_W-1:0]   nextId, nextIdNext;
  logic [LANES-1:0]  occ, occNext;
  logic [LEN_W-1:0]  rem [LANES];
  logic [LEN_W-1:0]  remNext [LANES];
  logic [ID_W-1:0]   id [LANES];
  logic [ID_W-1:0]   idNext [LANES];
  logic              accept;
  logic              loaded;

  assign len_ready  = (state == RUN) && !(&occ);
  assign accept     = len_valid && len_ready;
  assign lane_valid = occ;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_comb begin
    lane_row_id = '0;
    lane_last   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_row_id[i*ID_W +: ID_W] = id[i];
      lane_last[i] = occ[i] && (rem[i] == LEN_W'(1));
    end
  end

  always_comb begin
    stateNext  = state;
    rowsNext   = rowsQ;
    nextIdNext = nextId;
    occNext    = occ;
    remNext    = rem;
    idNext     = id;
    loaded     = 1'b0;

    if (advance) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (occ[i]) begin
          if (rem[i] == LEN_W'(1)) begin
            occNext[i] = 1'b0;
            remNext[i] = '0;
          end else begin
            remNext[i] = rem[i] - LEN_W'(1);
          end
        end
      end
    end

    // Eligibility uses occupancy at cycle start, so a lane freed this cycle waits one cycle.
    if (accept) begin
      nextIdNext = nextId + ID_W'(1);
      if (len_data != '0) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (!occ[i] && !loaded) begin
            occNext[i] = 1'b1;
            remNext[i] = len_data;
            idNext[i]  = nextId;
            loaded     = 1'b1;
          end
        end
      end
    end

    unique case (state)
      IDLE: begin
        if (start) begin
          rowsNext   = num_rows;
          nextIdNext = '0;
          stateNext  = (num_rows != '0) ? RUN : DRAIN;
        end
      end
      RUN: begin
        if (accept && (nextId + ID_W'(1) == rowsQ)) stateNext = DRAIN;
      end
      // Looking at next-cycle occupancy lets done follow the final consumption directly.
      DRAIN: begin
        if (occNext == '0) stateNext = DONE;
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rowsQ  <= '0;
      nextId <= '0;
      occ    <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        rem[i] <= '0;
        id[i]  <= '0;
      end
    end else begin
      state  <= stateNext;
      rowsQ  <= rowsNext;
      nextId <= nextIdNext;
      occ    <= occNext;
      for (int unsigned i = 0; i < LANES; i++) begin
        rem[i] <= remNext[i];
        id[i]  <= idNext[i];
      end
    end
  end

endmodule

// File: tb/tb_cisr_row_scheduler.sv
// Scoreboard bench for cisr_row_scheduler: expected per-lane consumptions are queued
// up front and a negedge monitor pops them as lanes present nonzeros.
module tb_cisr_row_scheduler;

  localparam int LANES = 4;
  localparam int ID_W  = 5;
  localparam int LEN_W = 5;

  logic                  clk = 1'b0;
  logic                  rstN;
  logic                  start;
  logic [ID_W-1:0]       numRows;
  logic                  lenValid;
  logic [LEN_W-1:0]      lenData;
  logic                  lenReady;
  logic                  advance;
  logic [LANES-1:0]      laneValid;
  logic [LANES*ID_W-1:0] laneRowId;
  logic [LANES-1:0]      laneLast;
  logic                  busy;
  logic                  done;

  int errors = 0;
  int checks = 0;
  int expQ[LANES][$];
  int lens[$];
  bit stallCheck = 0;

  cisr_row_scheduler #(.LANES(LANES), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(rstN), .start(start), .num_rows(numRows),
    .len_valid(lenValid), .len_data(lenData), .len_ready(lenReady),
    .advance(advance), .lane_valid(laneValid), .lane_row_id(laneRowId),
    .lane_last(laneLast), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the consumptions of one row: id repeated len times, last flag on the final one.
  task automatic expRow(input int lane, input int rid, input int len);
    for (int j = 0; j < len; j++) expQ[lane].push_back(rid * 2 + ((j == len - 1) ? 1 : 0));
  endtask

  always @(negedge clk) begin
    if (rstN && advance) begin
      for (int i = 0; i < LANES; i++) begin
        if (laneValid[i]) begin
          if (expQ[i].size() == 0) begin
            chk($sformatf("lane%0d_unexpected", i), int'(laneRowId[i*ID_W +: ID_W]), -1);
          end else begin
            chk($sformatf("lane%0d_id_last", i),
                int'(laneRowId[i*ID_W +: ID_W]) * 2 + int'(laneLast[i]), expQ[i].pop_front());
          end
        end
      end
    end
  end

  task automatic runPass(input int nr, input int doneCyc, input int stallFrom, input int stallLen,
                         input int restartAt, input int restartRows);
    int k;
    bit hs;
    k = 0;
    for (int t = 0; t <= doneCyc + 1; t++) begin
      start    = (t == 0) || (t == restartAt);
      numRows  = ID_W'((t == 0) ? nr : restartRows);
      advance  = !(t >= stallFrom && t < stallFrom + stallLen);
      lenValid = (k < lens.size());
      lenData  = lenValid ? LEN_W'(lens[k]) : '0;
      @(negedge clk);
      hs = lenValid && lenReady;
      chk($sformatf("done_c%0d", t), int'(done), (t == doneCyc) ? 1 : 0);
      chk($sformatf("busy_c%0d", t), int'(busy), (t >= 1 && t <= doneCyc) ? 1 : 0);
      if (nr == 0 && t == 1) chk("zero_rows_len_ready", int'(lenReady), 0);
      if (stallCheck && (t == 5 || t == 7)) begin
        chk("stall_valid", int'(laneValid), 15);
        chk("stall_row_id", int'(laneRowId), (3 << 15) | (2 << 10) | (1 << 5));
        chk("stall_last", int'(laneLast), 0);
        chk("stall_len_ready", int'(lenReady), 0);
      end
      @(posedge clk);
      #1;
      if (hs) k++;
    end
    start = 0; lenValid = 0; advance = 1;
    chk("rows_consumed", k, lens.size());
    for (int i = 0; i < LANES; i++) chk($sformatf("lane%0d_leftover", i), expQ[i].size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 0; start = 0; numRows = '0; lenValid = 0; lenData = '0; advance = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(laneValid), 0);
    chk("rst_row_id", int'(laneRowId), 0);
    chk("rst_last", int'(laneLast), 0);
    chk("rst_len_ready", int'(lenReady), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rstN = 1;
    @(posedge clk); #1;

    // Basic pass
    lens = '{3, 2, 4, 1};
    expRow(0, 0, 3); expRow(1, 1, 2); expRow(2, 2, 4); expRow(3, 3, 1);
    runPass(4, 8, -1, 0, -1, 0);

    // Lane reuse
    lens = '{1, 1, 1, 1, 2, 2};
    expRow(0, 0, 1); expRow(1, 1, 1); expRow(0, 2, 1); expRow(1, 3, 1);
    expRow(0, 4, 2); expRow(1, 5, 2);
    runPass(6, 9, -1, 0, -1, 0);

    // Zero-length row
    lens = '{2, 0, 1};
    expRow(0, 0, 2); expRow(1, 2, 1);
    runPass(3, 5, -1, 0, -1, 0);

    // Stall for 5 cycles
    lens = '{3, 3, 3, 3, 2, 2};
    expRow(0, 0, 3); expRow(1, 1, 3); expRow(2, 2, 3); expRow(3, 3, 3);
    expRow(0, 4, 2); expRow(1, 5, 2);
    stallCheck = 1;
    runPass(6, 14, 3, 5, -1, 0);
    stallCheck = 0;

    // num_rows = 0
    lens = {};
    runPass(0, 2, -1, 0, -1, 0);

    // start during RUN ignored
    lens = '{1, 1};
    expRow(0, 0, 1); expRow(1, 1, 1);
    runPass(2, 4, -1, 0, 2, 7);

    // Reset mid-pass with three lanes valid
    advance = 0; start = 1; numRows = ID_W'(4); lenValid = 1; lenData = LEN_W'(3);
    @(posedge clk); #1;
    start = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_reset_valid", int'(laneValid), 7);
    rstN = 0;
    #1;
    chk("async_rst_valid", int'(laneValid), 0);
    chk("async_rst_row_id", int'(laneRowId), 0);
    chk("async_rst_last", int'(laneLast), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_len_ready", int'(lenReady), 0);
    lenValid = 0; advance = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset_no_done", int'(done), 0);
    end
    @(posedge clk); #1;
    rstN = 1;
    @(posedge clk); #1;
    lens = '{1};
    expRow(0, 0, 1);
    runPass(1, 3, -1, 0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
